// File: rtl/player_life_controller.sv
// rtl/player_life_controller.sv - player life count and hit/respawn/game-over sequencer
// Optional feature macro: EXTRA_LIFE_EN (extraLife pulses grant a life, saturating at MAX_LIVES).
module player_life_controller #(
  parameter int INITIAL_LIVES = 3,
  parameter int MAX_LIVES     = 7,
  parameter int INVULN_FRAMES = 60,
  parameter int BLINK_PERIOD  = 4,
  parameter int GAMEOVER_HOLD = 90
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       startGame,
  input  logic       collisionMissile,
  input  logic       collisionMonster,
  input  logic       extraLife,
  output logic [2:0] lives,
  output logic       wasShot,
  output logic       invulnerable,
  output logic       playerVisible,
  output logic       playerEnable,
  output logic       gameOver
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_PLAY      = 2'd1;
  localparam logic [1:0] S_INVULN    = 2'd2;
  localparam logic [1:0] S_GAME_OVER = 2'd3;

  localparam int INV_W = $clog2(INVULN_FRAMES + 1);
  localparam int BLK_W = $clog2(BLINK_PERIOD + 1);
  localparam int HLD_W = $clog2(GAMEOVER_HOLD + 1);

  logic [1:0]       state;
  logic             miss_flag;
  logic             mon_flag;
  logic [INV_W-1:0] inv_cnt;
  logic [BLK_W-1:0] blink_cnt;
  logic [HLD_W-1:0] hld_cnt;

  logic       mon_eff;
  logic       miss_eff;
  logic       eval_edge;
  logic       fatal;
  logic       extra_ok;
  logic [2:0] lives_inc;

`ifdef EXTRA_LIFE_EN
  assign extra_ok = extraLife;
`else
  logic extra_life_unused;
  assign extra_life_unused = extraLife;
  assign extra_ok = 1'b0;
`endif

  // Collision inputs arriving on the evaluation cycle itself still count.
  assign mon_eff   = mon_flag | collisionMonster;
  assign miss_eff  = miss_flag | collisionMissile;
  assign eval_edge = startOfFrame && (state == S_PLAY || state == S_INVULN);
  assign lives_inc = (lives == 3'(MAX_LIVES)) ? lives : lives + 3'd1;

  always_comb begin
    fatal = 1'b0;
    if (eval_edge) begin
      if (mon_eff)
        fatal = 1'b1;
      else if (state == S_PLAY && miss_eff && lives <= 3'd1)
        fatal = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state         <= S_IDLE;
      lives         <= 3'd0;
      wasShot       <= 1'b0;
      invulnerable  <= 1'b0;
      playerVisible <= 1'b0;
      playerEnable  <= 1'b0;
      gameOver      <= 1'b0;
      miss_flag     <= 1'b0;
      mon_flag      <= 1'b0;
      inv_cnt       <= '0;
      blink_cnt     <= '0;
      hld_cnt       <= '0;
    end else begin
      wasShot <= 1'b0;
      if (fatal) begin
        // A monster kill never reports a shot; a last-life missile kill does.
        wasShot       <= (state == S_PLAY) && !mon_eff;
        state         <= S_GAME_OVER;
        lives         <= 3'd0;
        gameOver      <= 1'b1;
        invulnerable  <= 1'b0;
        playerVisible <= 1'b0;
        playerEnable  <= 1'b0;
        miss_flag     <= 1'b0;
        mon_flag      <= 1'b0;
        hld_cnt       <= HLD_W'(GAMEOVER_HOLD);
      end else begin
        case (state)
          S_IDLE: begin
            lives         <= 3'd0;
            invulnerable  <= 1'b0;
            playerVisible <= 1'b0;
            playerEnable  <= 1'b0;
            gameOver      <= 1'b0;
            miss_flag     <= 1'b0;
            mon_flag      <= 1'b0;
            if (startGame) begin
              lives         <= 3'(INITIAL_LIVES);
              playerVisible <= 1'b1;
              playerEnable  <= 1'b1;
              state         <= S_PLAY;
            end
          end

          S_PLAY: begin
            if (startOfFrame) begin
              miss_flag <= 1'b0;
              mon_flag  <= 1'b0;
              if (miss_eff) begin
                wasShot       <= 1'b1;
                lives         <= extra_ok ? lives : lives - 3'd1;
                state         <= S_INVULN;
                invulnerable  <= 1'b1;
                playerVisible <= 1'b0;
                inv_cnt       <= INV_W'(INVULN_FRAMES);
                blink_cnt     <= '0;
              end else if (extra_ok) begin
                lives <= lives_inc;
              end
            end else begin
              if (collisionMissile) miss_flag <= 1'b1;
              if (collisionMonster) mon_flag  <= 1'b1;
              if (extra_ok)         lives     <= lives_inc;
            end
          end

          S_INVULN: begin
            miss_flag <= 1'b0;
            if (extra_ok) lives <= lives_inc;
            if (startOfFrame) begin
              mon_flag <= 1'b0;
              inv_cnt  <= inv_cnt - 1'b1;
              if (blink_cnt == BLK_W'(BLINK_PERIOD - 1)) begin
                blink_cnt     <= '0;
                playerVisible <= ~playerVisible;
              end else begin
                blink_cnt <= blink_cnt + 1'b1;
              end
              if (inv_cnt <= INV_W'(1)) begin
                state         <= S_PLAY;
                invulnerable  <= 1'b0;
                playerVisible <= 1'b1;
                blink_cnt     <= '0;
              end
            end else if (collisionMonster) begin
              mon_flag <= 1'b1;
            end
          end

          default: begin
            lives         <= 3'd0;
            gameOver      <= 1'b1;
            playerVisible <= 1'b0;
            playerEnable  <= 1'b0;
            invulnerable  <= 1'b0;
            miss_flag     <= 1'b0;
            mon_flag      <= 1'b0;
            if (startOfFrame) begin
              if (hld_cnt <= HLD_W'(1)) begin
                hld_cnt  <= '0;
                gameOver <= 1'b0;
                state    <= S_IDLE;
              end else begin
                hld_cnt <= hld_cnt - 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_player_life_controller.sv
// tb/tb_player_life_controller.sv - directed self-checking bench for player_life_controller
module tb_player_life_controller;
  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       startGame = 1'b0;
  logic       collisionMissile = 1'b0;
  logic       collisionMonster = 1'b0;
  logic       extraLife = 1'b0;
  logic [2:0] lives;
  logic       wasShot, invulnerable, playerVisible, playerEnable, gameOver;
  int         checks = 0;
  int         errors = 0;

  player_life_controller dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .startGame(startGame),
    .collisionMissile(collisionMissile), .collisionMonster(collisionMonster),
    .extraLife(extraLife), .lives(lives), .wasShot(wasShot), .invulnerable(invulnerable),
    .playerVisible(playerVisible), .playerEnable(playerEnable), .gameOver(gameOver)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
  endtask

  task automatic frame_eval_only();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic start_game();
    startGame = 1'b1;
    tick();
    startGame = 1'b0;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    tick(); tick();
    resetN = 1'b1;
    checks++; if (lives !== 3'd0) begin errors++; $display("FAIL reset_lives: got %0d expected 0", lives); end
    checks++; if ({wasShot, invulnerable, playerVisible, playerEnable, gameOver} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000", {wasShot, invulnerable, playerVisible, playerEnable, gameOver}); end
    tick();
    checks++; if (playerEnable !== 1'b0) begin errors++; $display("FAIL idle_enable: got %b expected 0", playerEnable); end
  endtask

  task automatic test_start();
    start_game();
    checks++; if (lives !== 3'd3) begin errors++; $display("FAIL start_lives: got %0d expected 3", lives); end
    checks++; if ({playerEnable, playerVisible, gameOver, invulnerable} !== 4'b1100) begin
      errors++; $display("FAIL start_flags: got %b expected 1100", {playerEnable, playerVisible, gameOver, invulnerable}); end
  endtask

  task automatic test_missile_hit();
    logic exp_vis;
    collisionMissile = 1'b1; tick(); collisionMissile = 1'b0; tick();
    frame_eval_only();
    checks++; if ({wasShot, invulnerable, playerVisible} !== 3'b110) begin
      errors++; $display("FAIL hit_flags: got %b expected 110", {wasShot, invulnerable, playerVisible}); end
    checks++; if (lives !== 3'd2) begin errors++; $display("FAIL hit_lives: got %0d expected 2", lives); end
    tick();
    checks++; if (wasShot !== 1'b0) begin errors++; $display("FAIL hit_pulse_width: got %b expected 0", wasShot); end
    for (int k = 1; k <= 60; k++) begin
      // Missiles during invulnerability, both mid-frame and on the evaluation cycle.
      if (k <= 5) begin collisionMissile = 1'b1; tick(); collisionMissile = 1'b0; end
      if (k > 5 && k <= 10) collisionMissile = 1'b1;
      frame_eval_only();
      collisionMissile = 1'b0;
      if (k <= 10) begin
        checks++; if (wasShot !== 1'b0 || lives !== 3'd2) begin
          errors++; $display("FAIL invuln_missile_ignored f%0d: got shot=%b lives=%0d expected shot=0 lives=2", k, wasShot, lives); end
      end
      exp_vis = (k == 60) ? 1'b1 : (((k / 4) % 2) == 1);
      checks++; if (playerVisible !== exp_vis || invulnerable !== (k < 60)) begin
        errors++; $display("FAIL blink f%0d: got vis=%b inv=%b expected vis=%b inv=%b", k, playerVisible, invulnerable, exp_vis, k < 60); end
      tick();
    end
    checks++; if ({playerEnable, lives} !== {1'b1, 3'd2}) begin
      errors++; $display("FAIL back_to_play: got en=%b lives=%0d expected en=1 lives=2", playerEnable, lives); end
  endtask

  task automatic test_invuln_monster();
    collisionMissile = 1'b1; frame_eval_only(); collisionMissile = 1'b0;
    checks++; if ({wasShot, invulnerable, lives} !== {2'b11, 3'd1}) begin
      errors++; $display("FAIL second_hit: got shot=%b inv=%b lives=%0d expected 1 1 1", wasShot, invulnerable, lives); end
    tick(); frame(); frame();
    collisionMonster = 1'b1; tick(); collisionMonster = 1'b0; tick(); tick();
    checks++; if (gameOver !== 1'b0) begin errors++; $display("FAIL monster_latched_early: got %b expected 0", gameOver); end
    frame_eval_only();
    checks++; if ({gameOver, invulnerable, wasShot, lives} !== {3'b100, 3'd0}) begin
      errors++; $display("FAIL invuln_monster: got go=%b inv=%b shot=%b lives=%0d expected 1 0 0 0", gameOver, invulnerable, wasShot, lives); end
    tick();
    run_frames(90);
    checks++; if (gameOver !== 1'b0) begin errors++; $display("FAIL hold_done: got %b expected 0", gameOver); end
  endtask

  task automatic test_simultaneous_hold();
    start_game();
    tick();
    collisionMissile = 1'b1; collisionMonster = 1'b1;
    frame_eval_only();
    collisionMissile = 1'b0; collisionMonster = 1'b0;
    checks++; if ({gameOver, wasShot, lives} !== {2'b10, 3'd0}) begin
      errors++; $display("FAIL both_collide: got go=%b shot=%b lives=%0d expected 1 0 0", gameOver, wasShot, lives); end
    tick();
    for (int k = 1; k <= 90; k++) begin
      startGame = (k <= 85);
      frame_eval_only();
      if (k < 90) begin
        if (gameOver !== 1'b1 || playerEnable !== 1'b0) begin
          checks++; errors++; $display("FAIL hold f%0d: got go=%b en=%b expected go=1 en=0", k, gameOver, playerEnable); end
      end else begin
        checks++; if ({gameOver, playerEnable, lives} !== {2'b00, 3'd0}) begin
          errors++; $display("FAIL hold_exit: got go=%b en=%b lives=%0d expected 0 0 0", gameOver, playerEnable, lives); end
      end
      tick();
    end
    startGame = 1'b0;
    checks++; if ({gameOver, playerEnable} !== 2'b00) begin errors++; $display("FAIL hold_start_ignored: got %b expected 00", {gameOver, playerEnable}); end
  endtask

  task automatic test_last_life_and_reset();
    start_game();
    for (int h = 0; h < 2; h++) begin
      collisionMissile = 1'b1; frame_eval_only(); collisionMissile = 1'b0;
      tick(); run_frames(60);
    end
    checks++; if (lives !== 3'd1) begin errors++; $display("FAIL lives_before_last: got %0d expected 1", lives); end
    collisionMissile = 1'b1; frame_eval_only(); collisionMissile = 1'b0;
    checks++; if ({wasShot, gameOver, invulnerable, lives} !== {3'b110, 3'd0}) begin
      errors++; $display("FAIL last_life: got shot=%b go=%b inv=%b lives=%0d expected 1 1 0 0", wasShot, gameOver, invulnerable, lives); end
    tick();
    run_frames(90);
    start_game();
    collisionMissile = 1'b1; frame_eval_only(); collisionMissile = 1'b0;
    tick(); frame(); frame();
    resetN = 1'b0; tick(); resetN = 1'b1;
    checks++; if ({lives, wasShot, invulnerable, playerVisible, playerEnable, gameOver} !== 8'd0) begin
      errors++; $display("FAIL reset_mid_invuln: got lives=%0d flags=%b expected 0", lives, {wasShot, invulnerable, playerVisible, playerEnable, gameOver}); end
  endtask

  task automatic test_extra_life();
    start_game();
`ifdef EXTRA_LIFE_EN
    for (int i = 4; i <= 8; i++) begin
      extraLife = 1'b1; tick(); extraLife = 1'b0;
      checks++; if (lives !== 3'((i > 7) ? 7 : i)) begin
        errors++; $display("FAIL extra_sat step%0d: got %0d expected %0d", i, lives, (i > 7) ? 7 : i); end
    end
    collisionMissile = 1'b1; extraLife = 1'b1;
    frame_eval_only();
    collisionMissile = 1'b0; extraLife = 1'b0;
    checks++; if ({wasShot, invulnerable, lives} !== {2'b11, 3'd7}) begin
      errors++; $display("FAIL extra_cancel: got shot=%b inv=%b lives=%0d expected 1 1 7", wasShot, invulnerable, lives); end
`else
    extraLife = 1'b1; tick(); extraLife = 1'b0;
    checks++; if (lives !== 3'd3) begin errors++; $display("FAIL extra_ignored: got %0d expected 3", lives); end
    collisionMissile = 1'b1; extraLife = 1'b1;
    frame_eval_only();
    collisionMissile = 1'b0; extraLife = 1'b0;
    checks++; if ({wasShot, invulnerable, lives} !== {2'b11, 3'd2}) begin
      errors++; $display("FAIL extra_ignored_hit: got shot=%b inv=%b lives=%0d expected 1 1 2", wasShot, invulnerable, lives); end
`endif
  endtask

  initial begin
    test_reset();
    test_start();
    test_missile_hit();
    test_invuln_monster();
    test_simultaneous_hold();
    test_last_life_and_reset();
    test_extra_life();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
